// File: rtl/pooling_pkg.sv
// Shared types for the activation/pooling datapath.
// Element, vector and beat bundles plus the ReLU helper.
package pooling_pkg;

  localparam int PXW = 4;
  localparam int PQW = 32;
  localparam int PPW = 8;

  typedef logic [PQW-1:0] elem_t;
  typedef elem_t [PXW-1:0] vec_t;

  typedef struct packed {
    vec_t           d;
    logic [PPW-1:0] x;
    logic [PPW-1:0] y;
    logic           eol;
    logic           eof;
  } beat_t;

  // Sign-bit ReLU: any negative-signed word,
  // including -0, -inf and negative NaN, becomes +0.
  function automatic elem_t relu_f(input elem_t v);
    relu_f = v[PQW-1] ? '0 : v;
  endfunction

endpackage

// File: rtl/vec_skid_slice.sv
// Full-throughput register slice with a one-entry skid.
// Behaves as a 2-deep FIFO with registered ready.
module vec_skid_slice
  import pooling_pkg::*;
#(
  parameter type T = beat_t
) (
  input  logic clk,
  input  logic rstn,
  input  T     in_i,
  input  logic valid_i,
  output logic ready_o,
  output T     out_o,
  output logic valid_o,
  input  logic ready_i
);

  T     main_q, main_d;
  T     skid_q, skid_d;
  logic mv_q, mv_d;
  logic sv_q, sv_d;
  logic rdy_q;
  logic acc;
  logic drn;

  assign acc     = valid_i & rdy_q;
  assign drn     = mv_q & ready_i;
  assign ready_o = rdy_q;
  assign out_o   = main_q;
  assign valid_o = mv_q;

  // Next state: refill main from skid first, else from input; park in skid when main stalls.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    mv_d   = mv_q;
    sv_d   = sv_q;
    if (drn | ~mv_q) begin
      if (sv_q) begin
        main_d = skid_q;
        mv_d   = 1'b1;
        sv_d   = 1'b0;
      end else if (acc) begin
        main_d = in_i;
        mv_d   = 1'b1;
      end else begin
        mv_d   = 1'b0;
      end
    end else if (acc) begin
      skid_d = in_i;
      sv_d   = 1'b1;
    end
  end

  // State registers; ready is low in reset and follows skid emptiness after.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_q <= '0;
      skid_q <= '0;
      mv_q   <= 1'b0;
      sv_q   <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
      mv_q   <= mv_d;
      sv_q   <= sv_d;
      rdy_q  <= ~sv_d;
    end
  end

endmodule

// File: rtl/act_relu_stage.sv
// Activation stage feeding the pooling unit.
// Per-lane ReLU, raster position tags, registered skid slice.
module act_relu_stage
  import pooling_pkg::*;
#(
  parameter int XW       = PXW,
  parameter int QW       = PQW,
  parameter int ifsize_x = 8,
  parameter int ifsize_y = 8,
  parameter int relu_en  = 1,
  localparam int XB = (ifsize_x > 1) ? $clog2(ifsize_x) : 1,
  localparam int YB = (ifsize_y > 1) ? $clog2(ifsize_y) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [XW*QW-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [XW*QW-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XB-1:0]    pos_x_o,
  output logic [YB-1:0]    pos_y_o,
  output logic             eol_o,
  output logic             eof_o
);

  localparam logic [XB-1:0] XLAST = XB'(ifsize_x - 1);
  localparam logic [YB-1:0] YLAST = YB'(ifsize_y - 1);

  typedef struct packed {
    logic [XW*QW-1:0] d;
    logic [XB-1:0]    x;
    logic [YB-1:0]    y;
    logic             eol;
    logic             eof;
  } tbeat_t;

  logic [XB-1:0]    x_q, x_d;
  logic [YB-1:0]    y_q, y_d;
  logic             x_last;
  logic             y_last;
  logic             acc;
  logic [XW*QW-1:0] relu_d;
  tbeat_t           in_beat;
  tbeat_t           out_beat;

  assign acc    = valid_i & ready_o;
  assign x_last = (x_q == XLAST);
  assign y_last = (y_q == YLAST);

  for (genvar k = 0; k < XW; k++) begin : g_lane
    if (relu_en != 0) begin : g_on
      assign relu_d[k*QW +: QW] = relu_f(data_i[k*QW +: QW]);
    end else begin : g_off
      assign relu_d[k*QW +: QW] = data_i[k*QW +: QW];
    end
  end

  // Raster position of the next accepted beat, wrapping per row and per frame.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (acc) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Position counters; reset restarts the frame at (0,0).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign in_beat.d   = relu_d;
  assign in_beat.x   = x_q;
  assign in_beat.y   = y_q;
  assign in_beat.eol = x_last;
  assign in_beat.eof = x_last & y_last;

  vec_skid_slice #(
    .T (tbeat_t)
  ) u_slice (
    .clk     (clk),
    .rstn    (rstn),
    .in_i    (in_beat),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .out_o   (out_beat),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  assign data_o  = out_beat.d;
  assign pos_x_o = out_beat.x;
  assign pos_y_o = out_beat.y;
  assign eol_o   = out_beat.eol;
  assign eof_o   = out_beat.eof;

endmodule

// File: tb/tb_act_relu_stage.sv
// Bench for act_relu_stage: 4x3 ReLU instance and 8x8 pass-through instance.
// Both share one input stream and are checked against a FIFO-level model.
module tb_act_relu_stage;

  logic         clk     = 1'b0;
  logic         rstn    = 1'b1;
  logic [127:0] data_i  = '0;
  logic         valid_i = 1'b0;
  logic         ready_i = 1'b0;

  logic [127:0] d0_data, d1_data;
  logic         d0_rdy, d1_rdy, d0_vld, d1_vld;
  logic         d0_eol, d1_eol, d0_eof, d1_eof;
  logic [1:0]   d0_x, d0_y;
  logic [2:0]   d1_x, d1_y;

  int compared   = 0;
  int mismatched = 0;
  int seq        = 0;

  always #5 clk = ~clk;

  act_relu_stage #(
    .XW(4), .QW(32), .ifsize_x(4), .ifsize_y(3), .relu_en(1)
  ) u0 (
    .clk(clk), .rstn(rstn), .data_i(data_i), .valid_i(valid_i),
    .ready_o(d0_rdy), .data_o(d0_data), .valid_o(d0_vld),
    .ready_i(ready_i), .pos_x_o(d0_x), .pos_y_o(d0_y),
    .eol_o(d0_eol), .eof_o(d0_eof)
  );

  act_relu_stage #(
    .XW(4), .QW(32), .ifsize_x(8), .ifsize_y(8), .relu_en(0)
  ) u1 (
    .clk(clk), .rstn(rstn), .data_i(data_i), .valid_i(valid_i),
    .ready_o(d1_rdy), .data_o(d1_data), .valid_o(d1_vld),
    .ready_i(ready_i), .pos_x_o(d1_x), .pos_y_o(d1_y),
    .eol_o(d1_eol), .eof_o(d1_eof)
  );

  typedef struct packed {
    logic [127:0] d;
    logic [7:0]   x;
    logic [7:0]   y;
    logic         eol;
    logic         eof;
  } mb_t;

  mb_t mb [2][2];
  int  mocc [2] = '{0, 0};
  int  mcnt [2] = '{0, 0};
  bit  mrdy [2] = '{1'b0, 1'b0};

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] mkvec(input int s);
    logic [127:0] v;
    logic [31:0]  w;
    for (int k = 0; k < 4; k++) begin
      w = 32'h3F80_0000 + 32'(s * 4 + k);
      if ((s + k) % 3 == 0) w[31] = 1'b1;
      v[k*32 +: 32] = w;
    end
    return v;
  endfunction

  function automatic mb_t mkexp(input int dut, input int n,
                                input logic [127:0] din);
    mb_t b;
    int  w, h;
    w = (dut == 0) ? 4 : 8;
    h = (dut == 0) ? 3 : 8;
    b.x   = 8'(n % w);
    b.y   = 8'((n / w) % h);
    b.eol = ((n % w) == w - 1);
    b.eof = b.eol && (((n / w) % h) == h - 1);
    for (int k = 0; k < 4; k++)
      b.d[k*32 +: 32] = (dut == 0 && din[k*32+31]) ? 32'h0 : din[k*32 +: 32];
    return b;
  endfunction

  // Model: each DUT is a 2-deep in-order queue with registered ready.
  always @(posedge clk or negedge rstn) begin : mdl
    bit inx, outx;
    if (!rstn) begin
      for (int d = 0; d < 2; d++) begin
        mocc[d] = 0;
        mcnt[d] = 0;
        mrdy[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        inx  = valid_i && mrdy[d];
        outx = (mocc[d] > 0) && ready_i;
        if (outx) begin
          mb[d][0] = mb[d][1];
          mocc[d]  = mocc[d] - 1;
        end
        if (inx) begin
          mb[d][mocc[d]] = mkexp(d, mcnt[d], data_i);
          mcnt[d] = mcnt[d] + 1;
          mocc[d] = mocc[d] + 1;
        end
        mrdy[d] = (mocc[d] < 2);
      end
    end
  end

  // Compare both DUTs against the model every cycle.
  always @(negedge clk) begin
    chk("rdy0", 128'(d0_rdy), 128'(mrdy[0]));
    chk("vld0", 128'(d0_vld), 128'(mocc[0] > 0));
    if (mocc[0] > 0) begin
      chk("dat0", d0_data, mb[0][0].d);
      chk("x0", 128'(d0_x), 128'(mb[0][0].x));
      chk("y0", 128'(d0_y), 128'(mb[0][0].y));
      chk("eol0", 128'(d0_eol), 128'(mb[0][0].eol));
      chk("eof0", 128'(d0_eof), 128'(mb[0][0].eof));
    end else if (!rstn) begin
      chk("rdat0", d0_data, 128'h0);
      chk("rtag0", 128'({d0_x, d0_y, d0_eol, d0_eof}), 128'h0);
    end
    chk("rdy1", 128'(d1_rdy), 128'(mrdy[1]));
    chk("vld1", 128'(d1_vld), 128'(mocc[1] > 0));
    if (mocc[1] > 0) begin
      chk("dat1", d1_data, mb[1][0].d);
      chk("x1", 128'(d1_x), 128'(mb[1][0].x));
      chk("y1", 128'(d1_y), 128'(mb[1][0].y));
      chk("eol1", 128'(d1_eol), 128'(mb[1][0].eol));
      chk("eof1", 128'(d1_eof), 128'(mb[1][0].eof));
    end else if (!rstn) begin
      chk("rdat1", d1_data, 128'h0);
      chk("rtag1", 128'({d1_x, d1_y, d1_eol, d1_eof}), 128'h0);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rstn    = 1'b0;
    valid_i = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, out1, eofs, n;
    logic [12:0]  eol_p;
    logic [12:0]  eof_p;
    logic [127:0] vin;
    eol_p = 13'h0888;
    eof_p = 13'h0800;
    vin   = {32'hFFC00000, 32'h40490FDB, 32'h80000000, 32'hBF800000};

    // Reset release with idle input
    #1 rstn = 1'b0;
    tick();
    tick();
    chk("t1_rdy_in_rst", 128'(d0_rdy), 128'h0);
    chk("t1_vld_in_rst", 128'(d0_vld), 128'h0);
    rstn = 1'b1;
    tick();
    chk("t1_rdy_up", 128'(d0_rdy), 128'h1);
    chk("t1_vld_idle", 128'(d0_vld), 128'h0);
    tick();
    chk("t1_vld_idle2", 128'(d1_vld), 128'h0);

    // ReLU lane values, both relu settings
    ready_i = 1'b1;
    valid_i = 1'b1;
    data_i  = vin;
    tick();
    valid_i = 1'b0;
    chk("t2_relu_on", d0_data,
        {32'h0, 32'h40490FDB, 32'h0, 32'h0});
    chk("t2_relu_off", d1_data,
        {32'hFFC00000, 32'h40490FDB, 32'h80000000, 32'hBF800000});
    tick();

    // 4x3 frame back to back, plus first beat of next frame
    do_reset();
    tick();
    valid_i = 1'b1;
    data_i  = mkvec(seq);
    seq++;
    for (int k = 1; k <= 13; k++) begin
      tick();
      data_i = mkvec(seq);
      seq++;
      chk("t3_vld", 128'(d0_vld), 128'h1);
      chk("t3_eol", 128'(d0_eol), 128'(eol_p[k-1]));
      chk("t3_eof", 128'(d0_eof), 128'(eof_p[k-1]));
      if (k == 13) begin
        chk("t3_wrap_x", 128'(d0_x), 128'h0);
        chk("t3_wrap_y", 128'(d0_y), 128'h0);
      end
    end
    valid_i = 1'b0;
    tick();

    // Long stall: two beats taken, outputs held
    do_reset();
    ready_i = 1'b0;
    tick();
    valid_i = 1'b1;
    acc = 0;
    for (int c = 0; c < 13; c++) begin
      data_i = mkvec(seq);
      seq++;
      if (valid_i && d0_rdy) acc++;
      tick();
      if (c >= 1) begin
        chk("t5_hold_x", 128'(d0_x), 128'h0);
        chk("t5_hold_y", 128'(d0_y), 128'h0);
      end
    end
    chk("t5_accepted", 128'(acc), 128'h2);
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (4) tick();

    // Sparse downstream ready, full 8x8 frame
    do_reset();
    tick();
    valid_i = 1'b1;
    out1 = 0;
    eofs = 0;
    for (int c = 0; c < 3000 && out1 < 64; c++) begin
      ready_i = ((c % 21) < 3);
      data_i  = mkvec(seq);
      seq++;
      if (d1_vld && ready_i) begin
        out1++;
        if (d1_eof) eofs++;
        if (out1 == 64) begin
          chk("t4_last_eof", 128'(d1_eof), 128'h1);
          chk("t4_last_x", 128'(d1_x), 128'h7);
          chk("t4_last_y", 128'(d1_y), 128'h7);
        end
      end
      tick();
    end
    chk("t4_beats", 128'(out1), 128'd64);
    chk("t4_eofs", 128'(eofs), 128'h1);
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (4) tick();

    // Asynchronous reset in the middle of a frame
    do_reset();
    tick();
    valid_i = 1'b1;
    repeat (5) begin
      data_i = mkvec(seq);
      seq++;
      tick();
    end
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("t6_async_vld", 128'(d0_vld), 128'h0);
    chk("t6_async_rdy", 128'(d0_rdy), 128'h0);
    chk("t6_async_dat", d0_data, 128'h0);
    chk("t6_async_tag", 128'({d0_x, d0_y, d0_eol, d0_eof}), 128'h0);
    tick();
    tick();
    rstn = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 12; c++) begin
      data_i = mkvec(seq);
      seq++;
      tick();
      if (d0_vld) begin
        n++;
        if (n == 1) begin
          chk("t6_first_x", 128'(d0_x), 128'h0);
          chk("t6_first_y", 128'(d0_y), 128'h0);
        end
        chk("t6_eof", 128'(d0_eof), 128'(n == 12));
      end
    end
    chk("t6_beats", 128'(n), 128'd12);
    valid_i = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
